// File: rtl/rneabpx_if.sv
// Job/result handshake bundle for the RNEA backward-pass link engine.
// The scheduler drives the master side; the engine sits on the slave side.
interface rneabpx_if #(
    parameter int WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             link_in;
    logic [6*WIDTH-1:0]     f_link_in;
    logic [6*WIDTH-1:0]     f_child_in;
    logic [15*WIDTH-1:0]    xform_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [2:0]             link_out;
    logic [WIDTH-1:0]       tau_out;
    logic [6*WIDTH-1:0]     f_parent_out;

    modport master (
        output in_valid, link_in, f_link_in, f_child_in, xform_in, out_ready,
        input  in_ready, out_valid, link_out, tau_out, f_parent_out
    );

    modport slave (
        input  in_valid, link_in, f_link_in, f_child_in, xform_in, out_ready,
        output in_ready, out_valid, link_out, tau_out, f_parent_out
    );
endinterface

// File: rtl/rneabpx_seq.sv
// RNEA backward pass for one link: f_sum = f_link + f_child, tau = f_sum.AZ,
// f_parent = X^T * f_sum, one output column per cycle through a shared MAC row.
module rneabpx_seq #(
    parameter int WIDTH        = 32,
    parameter int DECIMAL_BITS = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    rneabpx_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SUM, XF, OUT} state_t;

    state_t                     r_state;
    logic                       r_in_ready;
    logic                       r_out_valid;
    logic [2:0]                 r_link;
    logic [2:0]                 r_c;
    logic [5:0][WIDTH-1:0]      r_flink;
    logic [5:0][WIDTH-1:0]      r_fchild;
    logic [5:0][WIDTH-1:0]      r_fsum;
    logic [5:0][WIDTH-1:0]      r_fpar;
    logic [14:0][WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]           r_tau;

    logic [5:0][5:0][WIDTH-1:0] w_x;
    logic [WIDTH-1:0]           w_acc;

    function automatic logic [WIDTH-1:0] fmul(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        p = p >>> DECIMAL_BITS;
        return p[WIDTH-1:0];
    endfunction

    // Expand the 15 sparse entries to the full 6x6 [row][col] transform.
    always_comb begin
        w_x = '0;
        for (int b = 0; b < 2; b++) begin
            w_x[3*b+0][3*b+0] = r_x[0];
            w_x[3*b+0][3*b+1] = r_x[1];
            w_x[3*b+0][3*b+2] = r_x[2];
            w_x[3*b+1][3*b+0] = r_x[3];
            w_x[3*b+1][3*b+1] = r_x[4];
            w_x[3*b+1][3*b+2] = r_x[5];
            w_x[3*b+2][3*b+1] = r_x[6];
            w_x[3*b+2][3*b+2] = r_x[7];
        end
        w_x[3][0] = r_x[8];
        w_x[3][1] = r_x[9];
        w_x[3][2] = r_x[10];
        w_x[4][0] = r_x[11];
        w_x[4][1] = r_x[12];
        w_x[4][2] = r_x[13];
        w_x[5][0] = r_x[14];
    end

    // Transposed product: column r_c of X dotted with f_sum.
    always_comb begin
        w_acc = '0;
        for (int r = 0; r < 6; r++)
            w_acc = w_acc + fmul(w_x[r][r_c], r_fsum[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_link      <= '0;
            r_c         <= '0;
            r_flink     <= '0;
            r_fchild    <= '0;
            r_fsum      <= '0;
            r_fpar      <= '0;
            r_x         <= '0;
            r_tau       <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid && r_in_ready) begin
                    r_link     <= bus.link_in;
                    r_flink    <= bus.f_link_in;
                    r_fchild   <= bus.f_child_in;
                    r_x        <= bus.xform_in;
                    r_in_ready <= 1'b0;
                    r_state    <= SUM;
                end
                SUM: begin
                    for (int k = 0; k < 6; k++)
                        r_fsum[k] <= r_flink[k] + r_fchild[k];
                    r_tau   <= r_flink[2] + r_fchild[2];
                    r_c     <= '0;
                    r_state <= XF;
                end
                XF: begin
                    r_fpar[r_c] <= w_acc;
                    if (r_c == 3'd5) r_state <= OUT;
                    else             r_c     <= r_c + 3'd1;
                end
                OUT: begin
                    // First OUT cycle only raises valid, so the last lane write settles first.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.link_out     = r_link;
    assign bus.tau_out      = r_tau;
    assign bus.f_parent_out = r_fpar;
endmodule

// File: tb/tb_rneabpx_seq.sv
// Scoreboard bench for rneabpx_seq: expectations pushed on accept, popped on result.
module tb_rneabpx_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rneabpx_if #(.WIDTH(W)) bus ();
    rneabpx_seq #(.WIDTH(W), .DECIMAL_BITS(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [2:0]   lk;
        logic [31:0]  tau;
        logic [191:0] fp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        p = p >>> 16;
        return p[31:0];
    endfunction

    function automatic exp_t model(input logic [2:0] lk, input logic [5:0][31:0] fl,
                                   input logic [5:0][31:0] fc, input logic [14:0][31:0] x);
        logic [31:0] m [6][6];
        logic [31:0] s [6];
        logic [31:0] acc;
        exp_t e;
        for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) m[r][c] = '0;
        // E on both diagonal blocks, sparse linear-angular block below
        m[0][0] = x[0]; m[0][1] = x[1]; m[0][2] = x[2];
        m[1][0] = x[3]; m[1][1] = x[4]; m[1][2] = x[5];
        m[2][1] = x[6]; m[2][2] = x[7];
        m[3][3] = x[0]; m[3][4] = x[1]; m[3][5] = x[2];
        m[4][3] = x[3]; m[4][4] = x[4]; m[4][5] = x[5];
        m[5][4] = x[6]; m[5][5] = x[7];
        m[3][0] = x[8];  m[3][1] = x[9];  m[3][2] = x[10];
        m[4][0] = x[11]; m[4][1] = x[12]; m[4][2] = x[13];
        m[5][0] = x[14];
        for (int r = 0; r < 6; r++) s[r] = fl[r] + fc[r];
        e.lk  = lk;
        e.tau = s[2];
        e.fp  = '0;
        for (int c = 0; c < 6; c++) begin
            acc = '0;
            for (int r = 0; r < 6; r++) acc = acc + fmul(m[r][c], s[r]);
            e.fp[c*32 +: 32] = acc;
        end
        return e;
    endfunction

    task automatic drive(input logic [2:0] lk, input logic [5:0][31:0] fl,
                         input logic [5:0][31:0] fc, input logic [14:0][31:0] x);
        bus.link_in    = lk;
        bus.f_link_in  = fl;
        bus.f_child_in = fc;
        bus.xform_in   = x;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < 30);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb"}, 192'(0), 192'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_link"}, 192'(bus.link_out), 192'(e.lk));
            check({tag, "_tau"},  192'(bus.tau_out),  192'(e.tau));
            check({tag, "_fp"},   bus.f_parent_out,   e.fp);
        end
    endtask

    task automatic do_job(input logic [2:0] lk, input logic [5:0][31:0] fl,
                          input logic [5:0][31:0] fc, input logic [14:0][31:0] x,
                          input string tag);
        int lat;
        @(negedge clk);
        drive(lk, fl, fc, x);
        bus.in_valid = 1'b1;
        lat = 0;
        while (!bus.in_ready && lat < 40) begin @(negedge clk); lat++; end
        check({tag, "_rdy"}, 192'(bus.in_ready), 192'(1));
        sb.push_back(model(lk, fl, fc, x));
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.link_in    = ~lk;
        bus.f_link_in  = ~bus.f_link_in;
        bus.f_child_in = ~bus.f_child_in;
        bus.xform_in   = ~bus.xform_in;
        wait_out(lat);
        check({tag, "_lat"}, 192'(lat), 192'(8));
        pop_cmp(tag);
        @(posedge clk); #1;
        check({tag, "_vld0"}, 192'(bus.out_valid), 192'(0));
    endtask

    logic [14:0][31:0] xid, xa;
    logic [5:0][31:0]  fl, fc, fz;
    exp_t              eh;
    int                lat;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(3'd0, '0, '0, '0);
        xid = '0;
        xid[0] = 32'h10000; xid[4] = 32'h10000; xid[7] = 32'h10000;
        fz = '0;

        repeat (3) @(negedge clk);
        check("rst_rdy",  192'(bus.in_ready),  192'(1));
        check("rst_vld",  192'(bus.out_valid), 192'(0));
        check("rst_link", 192'(bus.link_out),  192'(0));
        check("rst_tau",  192'(bus.tau_out),   192'(0));
        check("rst_fp",   bus.f_parent_out,    192'(0));
        rst_n = 1'b1;

        // identity transform passes f_sum straight through
        for (int k = 0; k < 6; k++) fl[k] = 32'(k + 1) << 16;
        do_job(3'd5, fl, fz, xid, "ident");

        fl = '0; fc = '0; fl[2] = 32'h10000; fc[2] = 32'h8000;
        do_job(3'd2, fl, fc, xid, "tau");

        xa = xid; xa[9] = 32'h10000;
        fl = '0; fl[3] = 32'h20000;
        do_job(3'd3, fl, fz, xa, "lxay");

        xa = '0; xa[0] = 32'hFFFF8000;
        fl = '0; fl[0] = 32'h1;
        do_job(3'd1, fl, fz, xa, "floor");

        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 6; k++) begin fl[k] = $urandom; fc[k] = $urandom; end
            for (int k = 0; k < 15; k++) xa[k] = $urandom;
            do_job(3'($urandom_range(0, 7)), fl, fc, xa, "rand");
        end

        // backpressure: result must hold while in_valid pulses and is refused
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) fl[k] = 32'(k * 3 + 1) << 12;
        @(negedge clk);
        drive(3'd6, fl, fz, xid);
        bus.in_valid = 1'b1;
        sb.push_back(model(3'd6, fl, fz, xid));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("bp_lat", 192'(lat), 192'(8));
        eh = sb.pop_front();
        for (int k = 0; k < 6; k++) fc[k] = 32'(k) << 14;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 2 == 0);
            drive(3'd7, fc, fl, xid);
            check("bp_rdy",  192'(bus.in_ready),  192'(0));
            check("bp_vld",  192'(bus.out_valid), 192'(1));
            check("bp_link", 192'(bus.link_out),  192'(eh.lk));
            check("bp_tau",  192'(bus.tau_out),   192'(eh.tau));
            check("bp_fp",   bus.f_parent_out,    eh.fp);
        end
        sb.push_back(model(3'd7, fc, fl, xid));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_hs_vld", 192'(bus.out_valid), 192'(0));
        check("bp_hs_rdy", 192'(bus.in_ready),  192'(1));
        @(posedge clk); #1;
        check("bp_acc", 192'(bus.in_ready), 192'(0));
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("bp2_lat", 192'(lat), 192'(8));
        pop_cmp("bp2");
        @(posedge clk); #1;

        // reset while the column counter sits at 3
        for (int k = 0; k < 6; k++) fl[k] = 32'h50000;
        @(negedge clk);
        drive(3'd4, fl, fl, xid);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_vld",  192'(bus.out_valid), 192'(0));
        check("ar_tau",  192'(bus.tau_out),   192'(0));
        check("ar_fp",   bus.f_parent_out,    192'(0));
        check("ar_link", 192'(bus.link_out),  192'(0));
        check("ar_rdy",  192'(bus.in_ready),  192'(1));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) fl[k] = 32'(k + 2) << 15;
        xa = xid; xa[14] = 32'h8000; xa[1] = 32'hFFFF0000;
        do_job(3'd5, fl, fz, xa, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
